// File: rtl/pipe_controller.sv
// -----------------------------------------------------------------------------
// pipe_controller
//
// Generates the two scrolling pipe obstacles for a 640x480 playfield. Both
// pipes move left by STEP pixels once every TICK_DIV clocks while running,
// wrap back to WRAP_X with a fresh pseudo-random gap height, and the number
// of pipes that slide past the bird column is counted as the score.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset (also seeds the LFSR)
//   start      in   IDLE -> RUN; ignored in other states
//   collision  in   level from the collision detector; RUN -> HALT
//   restart    in   back to IDLE with the initial layout, from any state
//   pipe1_x    out  pipe 1 right edge x            (registered)
//   pipe1_y    out  pipe 1 gap bottom y            (registered)
//   pipe2_x    out  pipe 2 right edge x            (registered)
//   pipe2_y    out  pipe 2 gap bottom y            (registered)
//   score      out  pipes passed, saturating at 1023 (registered)
//   running    out  high only while in RUN         (registered)
//
// The FSM state is held in state_q so a checker can bind to it directly.
// -----------------------------------------------------------------------------
module pipe_controller #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned STEP     = 1,
    parameter int unsigned WRAP_X   = 710,
    parameter int unsigned SPACING  = 355,
    parameter int unsigned Y_MIN    = 150,
    parameter int unsigned BIRD_X   = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        collision,
    input  logic        restart,
    output logic [10:0] pipe1_x,
    output logic [10:0] pipe1_y,
    output logic [10:0] pipe2_x,
    output logic [10:0] pipe2_y,
    output logic [9:0]  score,
    output logic        running
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [10:0]   STEP_L    = 11'(STEP);
    localparam logic [10:0]   WRAP_L    = 11'(WRAP_X);
    localparam logic [10:0]   P2_INIT_X = 11'(WRAP_X + SPACING);
    localparam logic [10:0]   Y_MIN_L   = 11'(Y_MIN);
    localparam logic [10:0]   BIRD_L    = 11'(BIRD_X);
    localparam logic [10:0]   P1_INIT_Y = 11'd300;
    localparam logic [10:0]   P2_INIT_Y = 11'd240;
    localparam logic [10:0]   SCORE_MAX = 11'd1023;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [10:0]   pipe1_x_q, pipe1_x_d;
    logic [10:0]   pipe1_y_q, pipe1_y_d;
    logic [10:0]   pipe2_x_q, pipe2_x_d;
    logic [10:0]   pipe2_y_q, pipe2_y_d;
    logic [9:0]    score_q, score_d;
    logic          running_q, running_d;

    // Per-pipe step results, computed every cycle and only used on a step.
    logic          p1_wrap, p2_wrap;
    logic [10:0]   p1_next, p2_next;
    logic          p1_cross, p2_cross;
    logic [10:0]   gap_y;
    logic [10:0]   score_sum;

    always_comb begin
        // Fibonacci LFSR, taps 8,6,5,4; runs in every state.
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        // Both pipes share the current LFSR value if they wrap together.
        gap_y = Y_MIN_L + {3'b000, lfsr_q};

        p1_wrap  = (pipe1_x_q <= STEP_L);
        p1_next  = p1_wrap ? WRAP_L : (pipe1_x_q - STEP_L);
        p1_cross = !p1_wrap && (pipe1_x_q >= BIRD_L) && (p1_next < BIRD_L);

        p2_wrap  = (pipe2_x_q <= STEP_L);
        p2_next  = p2_wrap ? WRAP_L : (pipe2_x_q - STEP_L);
        p2_cross = !p2_wrap && (pipe2_x_q >= BIRD_L) && (p2_next < BIRD_L);

        score_sum = {1'b0, score_q} + 11'(p1_cross) + 11'(p2_cross);

        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        pipe1_x_d  = pipe1_x_q;
        pipe1_y_d  = pipe1_y_q;
        pipe2_x_d  = pipe2_x_q;
        pipe2_y_d  = pipe2_y_q;
        score_d    = score_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (collision) begin
                    // Collision wins over a coinciding tick: no step.
                    state_d    = S_HALT;
                    tick_cnt_d = '0;
                end else if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    pipe1_x_d  = p1_next;
                    pipe2_x_d  = p2_next;
                    if (p1_wrap) pipe1_y_d = gap_y;
                    if (p2_wrap) pipe2_y_d = gap_y;
                    score_d = (score_sum > SCORE_MAX) ? 10'd1023 : score_sum[9:0];
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            S_HALT: begin
                tick_cnt_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Restart overrides everything above but leaves the LFSR running.
        if (restart) begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            pipe1_x_d  = WRAP_L;
            pipe1_y_d  = P1_INIT_Y;
            pipe2_x_d  = P2_INIT_X;
            pipe2_y_d  = P2_INIT_Y;
            score_d    = '0;
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            lfsr_q     <= 8'hA5;
            pipe1_x_q  <= WRAP_L;
            pipe1_y_q  <= P1_INIT_Y;
            pipe2_x_q  <= P2_INIT_X;
            pipe2_y_q  <= P2_INIT_Y;
            score_q    <= '0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            lfsr_q     <= lfsr_d;
            pipe1_x_q  <= pipe1_x_d;
            pipe1_y_q  <= pipe1_y_d;
            pipe2_x_q  <= pipe2_x_d;
            pipe2_y_q  <= pipe2_y_d;
            score_q    <= score_d;
            running_q  <= running_d;
        end
    end

    assign pipe1_x = pipe1_x_q;
    assign pipe1_y = pipe1_y_q;
    assign pipe2_x = pipe2_x_q;
    assign pipe2_y = pipe2_y_q;
    assign score   = score_q;
    assign running = running_q;

endmodule

// File: tb/tb_pipe_controller.sv
// -----------------------------------------------------------------------------
// tb_pipe_controller
//
// Drives pipe_controller with TICK_DIV=4, STEP=1 and compares its outputs
// every cycle against a behavioural game model (integer positions, a phase
// counter and a mode), plus scenario-specific expectations.
//
// Valid/ready note: this block has no handshakes; inputs are plain levels
// sampled on every rising clock edge.
// -----------------------------------------------------------------------------
module tb_pipe_controller;

    localparam int TICK_DIV = 4;
    localparam int STEP     = 1;
    localparam int WRAP_X   = 710;
    localparam int SPACING  = 355;
    localparam int Y_MIN    = 150;
    localparam int BIRD_X   = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        collision = 1'b0;
    logic        restart = 1'b0;
    logic [10:0] pipe1_x, pipe1_y, pipe2_x, pipe2_y;
    logic [9:0]  score;
    logic        running;

    pipe_controller #(
        .TICK_DIV (TICK_DIV),
        .STEP     (STEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .collision (collision),
        .restart   (restart),
        .pipe1_x   (pipe1_x),
        .pipe1_y   (pipe1_y),
        .pipe2_x   (pipe2_x),
        .pipe2_y   (pipe2_y),
        .score     (score),
        .running   (running)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    // mode: 0 = idle, 1 = scrolling, 2 = frozen
    int         m_mode, m_phase, m_score;
    int         m_p1x, m_p1y, m_p2x, m_p2y;
    logic [7:0] m_lfsr;

    task automatic load_layout();
        m_p1x = WRAP_X;            m_p1y = 300;
        m_p2x = WRAP_X + SPACING;  m_p2y = 240;
        m_score = 0; m_mode = 0; m_phase = 0;
    endtask

    task automatic advance(inout int x, inout int y, input logic [7:0] l, inout int c);
        if (x <= STEP) begin
            x = WRAP_X;
            y = Y_MIN + int'(l);
        end else begin
            if (x >= BIRD_X && x - STEP < BIRD_X) c++;
            x = x - STEP;
        end
    endtask

    task automatic model_update();
        logic [7:0] l;
        int c;
        l = m_lfsr;
        if (reset) begin
            load_layout();
            m_lfsr = 8'hA5;
            return;
        end
        m_lfsr = {l[6:0], ^(l & 8'hB8)};
        if (restart) begin
            load_layout();
            return;
        end
        case (m_mode)
            0: if (start) m_mode = 1;
            1: begin
                if (collision) begin
                    m_mode = 2;
                    m_phase = 0;
                end else if (m_phase == TICK_DIV - 1) begin
                    m_phase = 0;
                    c = 0;
                    advance(m_p1x, m_p1y, l, c);
                    advance(m_p2x, m_p2y, l, c);
                    m_score = (m_score + c > 1023) ? 1023 : m_score + c;
                end else begin
                    m_phase++;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [54:0] obs_vec();
        return {pipe1_x, pipe1_y, pipe2_x, pipe2_y, score, running};
    endfunction

    function automatic logic [54:0] exp_vec();
        return {11'(m_p1x), 11'(m_p1y), 11'(m_p2x), 11'(m_p2y), 10'(m_score), m_mode == 1};
    endfunction

    // ---------------- driver ----------------
    // Inputs change at the falling edge; the model consumes them at the
    // rising edge and outputs are sampled back at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [54:0] init_v;
        init_v = {11'd710, 11'd300, 11'd1065, 11'd240, 10'd0, 1'b0};
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_vec++;
        if (obs_vec() !== init_v) begin
            n_err++;
            $display("FAIL reset_layout: got %h want %h", obs_vec(), init_v);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_vec++;
            if (obs_vec() !== init_v) begin
                n_err++;
                $display("FAIL idle_hold cyc %0d: got %h want %h", i, obs_vec(), init_v);
            end
        end
    endtask

    task automatic test_scroll();
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_vec++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL run_after_start: running=%b want 1", running);
        end
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL scroll cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            n_vec++;
            if (int'(pipe2_x) - int'(pipe1_x) != SPACING) begin
                n_err++;
                $display("FAIL scroll_spacing cyc %0d: got %0d want %0d", i,
                         int'(pipe2_x) - int'(pipe1_x), SPACING);
            end
        end
        n_vec++;
        if (pipe1_x !== 11'd700) begin
            n_err++;
            $display("FAIL scroll_10_steps: pipe1_x=%0d want 700", pipe1_x);
        end
    endtask

    task automatic test_score_first();
        int budget;
        budget = 0;
        while (m_p1x != 99 && budget < 4000) begin
            start = ($urandom_range(0, 9) == 0);
            cycle();
            budget++;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL score1_track cyc %0d: got %h want %h", budget, obs_vec(), exp_vec());
            end
        end
        start = 1'b0;
        n_vec++;
        if (budget >= 4000 || pipe1_x !== 11'd99 || score !== 10'd1) begin
            n_err++;
            $display("FAIL score_first: x=%0d score=%0d want x=99 score=1", pipe1_x, score);
        end
    endtask

    task automatic test_wrap();
        int budget;
        int off;
        budget = 0;
        while (m_p1x != 1 && budget < 2000) begin
            start = ($urandom_range(0, 9) == 0);
            cycle();
            budget++;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap_track cyc %0d: got %h want %h", budget, obs_vec(), exp_vec());
            end
        end
        while (m_p1x == 1 && budget < 2000) begin
            cycle();
            budget++;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap_edge cyc %0d: got %h want %h", budget, obs_vec(), exp_vec());
            end
        end
        start = 1'b0;
        off = (int'(pipe2_x) - int'(pipe1_x) + WRAP_X) % WRAP_X;
        n_vec++;
        if (budget >= 2000 || pipe1_x !== 11'd710 || pipe1_y < 11'd151 || pipe1_y > 11'd405
            || off != SPACING) begin
            n_err++;
            $display("FAIL wrap_reload: x=%0d y=%0d off=%0d want x=710 y in 151..405 off=355",
                     pipe1_x, pipe1_y, off);
        end
    endtask

    task automatic test_score_second();
        int budget;
        budget = 0;
        while (m_score != 2 && budget < 2000) begin
            cycle();
            budget++;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL score2_track cyc %0d: got %h want %h", budget, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (budget >= 2000 || score !== 10'd2 || pipe2_x !== 11'd99) begin
            n_err++;
            $display("FAIL score_second: score=%0d x2=%0d want score=2 x2=99", score, pipe2_x);
        end
    endtask

    task automatic test_collision();
        int budget;
        logic [43:0] frozen;
        budget = 0;
        while (m_phase != TICK_DIV - 1 && budget < 10) begin
            cycle();
            budget++;
        end
        n_vec++;
        if (budget >= 10) begin
            n_err++;
            $display("FAIL collide_align: phase=%0d want %0d", m_phase, TICK_DIV - 1);
        end
        frozen = {pipe1_x, pipe1_y, pipe2_x, pipe2_y};
        collision = 1'b1;
        cycle();
        n_vec++;
        if (running !== 1'b0 || {pipe1_x, pipe1_y, pipe2_x, pipe2_y} !== frozen) begin
            n_err++;
            $display("FAIL collide_no_step: running=%b pos=%h want 0 %h",
                     running, {pipe1_x, pipe1_y, pipe2_x, pipe2_y}, frozen);
        end
        for (int i = 0; i < 50; i++) begin
            collision = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 3) == 0);
            cycle();
            n_vec++;
            if (obs_vec() !== exp_vec() || {pipe1_x, pipe1_y, pipe2_x, pipe2_y} !== frozen
                || running !== 1'b0 || score !== 10'd2) begin
                n_err++;
                $display("FAIL halt_frozen cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        collision = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_restart();
        logic [54:0] init_v;
        init_v = {11'd710, 11'd300, 11'd1065, 11'd240, 10'd0, 1'b0};
        restart = 1'b1;
        start = 1'b1;
        cycle();
        restart = 1'b0;
        start = 1'b0;
        n_vec++;
        if (obs_vec() !== init_v) begin
            n_err++;
            $display("FAIL restart_layout: got %h want %h", obs_vec(), init_v);
        end
        for (int i = 0; i < 3; i++) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        n_vec++;
        if (pipe1_x !== 11'd708 || pipe2_x !== 11'd1063 || running !== 1'b1) begin
            n_err++;
            $display("FAIL restart_resume: x1=%0d x2=%0d run=%b want 708 1063 1",
                     pipe1_x, pipe2_x, running);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            restart   = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 19) == 0);
            collision = ($urandom_range(0, 59) == 0);
            cycle();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        reset = 1'b0; restart = 1'b0; start = 1'b0; collision = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        m_lfsr = 8'h00;
        load_layout();
        @(negedge clk);
        test_reset();
        test_scroll();
        test_score_first();
        test_wrap();
        test_score_second();
        test_collision();
        test_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
